segre_main_memory: RTL and testbench

Line-granular main-memory model sitting directly downstream of the cache arbiter. It accepts one cache-line read or write request at a time through a valid/ready handshake and holds it for a fixed, parameterised latency. It then returns a one-cycle response carrying the cache line and the originating cache ID, which the arbiter uses to route the line back to the instruction or data cache.

---
 rtl/segre_main_memory.sv | 124 ++++++++++++
 tb/tb_segre_main_memory.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_main_memory.sv
// Line-granular main memory: accepts one read/write at a time, holds it for
// LATENCY cycles, then returns a one-cycle response tagged with the cache ID.
module segre_main_memory #(
  parameter int ADDR_SIZE             = 32,
  parameter int CACHE_LINE_SIZE_BYTES = 16,
  parameter int MEM_LINES             = 4096,
  parameter int LATENCY               = 5
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic                                 req_rd_i,
  input  logic                                 req_wr_i,
  input  logic [ADDR_SIZE-1:0]                 req_addr_i,
  input  logic [CACHE_LINE_SIZE_BYTES*8-1:0]   req_data_i,
  input  logic                                 req_cache_id_i,
  output logic                                 rsp_valid_o,
  output logic                                 rsp_cache_id_o,
  output logic [CACHE_LINE_SIZE_BYTES*8-1:0]   rsp_data_o
);

  localparam int LINE_W = CACHE_LINE_SIZE_BYTES * 8;
  localparam int OFF_W  = $clog2(CACHE_LINE_SIZE_BYTES);
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int CNT_W  = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  // Handshake: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high and at least one of rd/wr is set.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESPOND = 2'd2} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              load_rsp;
  logic [IDX_W-1:0]  idx_in;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic              cache_id_q;
  logic [LINE_W-1:0] data_q;
  logic              src_wr;
  logic              src_id;
  logic [IDX_W-1:0]  src_idx;
  logic [LINE_W-1:0] src_data;
  logic              unused_addr;

  logic [LINE_W-1:0] store [MEM_LINES];

  assign accept      = (state == IDLE) && req_valid_i && (req_rd_i || req_wr_i);
  assign idx_in      = req_addr_i[OFF_W +: IDX_W];
  assign unused_addr = ^req_addr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (LATENCY == 1) ? RESPOND : BUSY;
      BUSY:    if (cnt == CNT_W'(1)) state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state == IDLE);
    rsp_valid_o = (state == RESPOND);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt        <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      cache_id_q <= 1'b0;
    end else if (accept) begin
      cnt        <= CNT_W'(LATENCY - 1);
      wr_q       <= req_wr_i;
      idx_q      <= idx_in;
      data_q     <= req_data_i;
      cache_id_q <= req_cache_id_i;
    end else if (state == BUSY) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // With LATENCY == 1 the response is loaded on the acceptance edge itself,
  // so the source must bypass the request register while still in IDLE.
  always_comb begin
    if (state == IDLE) begin
      src_wr   = req_wr_i;
      src_id   = req_cache_id_i;
      src_idx  = idx_in;
      src_data = req_data_i;
    end else begin
      src_wr   = wr_q;
      src_id   = cache_id_q;
      src_idx  = idx_q;
      src_data = data_q;
    end
  end

  assign load_rsp = (state_next == RESPOND) && (state != RESPOND);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_data_o     <= '0;
      rsp_cache_id_o <= 1'b0;
    end else if (load_rsp) begin
      rsp_data_o     <= src_wr ? src_data : store[src_idx];
      rsp_cache_id_o <= src_id;
    end
  end

  // A reset landing in RESPOND discards the pending write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state == RESPOND) && wr_q) store[idx_q] <= data_q;
  end

endmodule

// File: tb/tb_segre_main_memory.sv
// Bench for segre_main_memory: two instances (LATENCY 5 and 1) checked every
// cycle against a line-array model with an expected-response queue.
module tb_segre_main_memory;

  localparam int AW    = 32;
  localparam int ML    = 4096;
  localparam int LW    = 128;
  localparam int LAT_A = 5;
  localparam int LAT_B = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit reported = 0;
  bit done_a = 0;
  bit done_b = 0;

  logic          rst_a = 1'b1, valid_a = 1'b0, rd_a = 1'b0, wr_a = 1'b0, id_a = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic [LW-1:0] wdata_a = '0;
  logic          ready_a, rvalid_a, rid_a;
  logic [LW-1:0] rdata_a;

  logic          rst_b = 1'b1, valid_b = 1'b0, rd_b = 1'b0, wr_b = 1'b0, id_b = 1'b0;
  logic [AW-1:0] addr_b = '0;
  logic [LW-1:0] wdata_b = '0;
  logic          ready_b, rvalid_b, rid_b;
  logic [LW-1:0] rdata_b;

  segre_main_memory #(.ADDR_SIZE(AW), .CACHE_LINE_SIZE_BYTES(16), .MEM_LINES(ML), .LATENCY(LAT_A)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_valid_i(valid_a), .req_ready_o(ready_a),
    .req_rd_i(rd_a), .req_wr_i(wr_a), .req_addr_i(addr_a), .req_data_i(wdata_a),
    .req_cache_id_i(id_a), .rsp_valid_o(rvalid_a), .rsp_cache_id_o(rid_a), .rsp_data_o(rdata_a)
  );

  segre_main_memory #(.ADDR_SIZE(AW), .CACHE_LINE_SIZE_BYTES(16), .MEM_LINES(ML), .LATENCY(LAT_B)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_valid_i(valid_b), .req_ready_o(ready_b),
    .req_rd_i(rd_b), .req_wr_i(wr_b), .req_addr_i(addr_b), .req_data_i(wdata_b),
    .req_cache_id_i(id_b), .rsp_valid_o(rvalid_b), .rsp_cache_id_o(rid_b), .rsp_data_o(rdata_b)
  );

  // scoreboard / model
  typedef struct packed {
    logic          wr;
    logic [11:0]   idx;
    logic [31:0]   due;
    logic          id;
    logic [LW-1:0] data;
  } rsp_t;

  rsp_t          exp_q_a[$];
  rsp_t          exp_q_b[$];
  logic [LW-1:0] mstore [2][ML];
  int            next_ready [2];
  logic [LW-1:0] held_data [2];
  logic          held_id [2];
  bit            model_on [2];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input int d, input int k, input logic rst, input logic v,
                            input logic rd, input logic wr, input logic [AW-1:0] addr,
                            input logic [LW-1:0] wd, input logic id, input logic ready,
                            input logic rv, input logic [LW-1:0] rdat, input logic rid);
    rsp_t        head;
    rsp_t        ent;
    bit          due_now;
    int          lat;
    logic [11:0] idx;
    due_now = 0;
    head    = '0;
    lat     = (d == 0) ? LAT_A : LAT_B;
    if (!model_on[d]) begin
      if (rst) begin
        model_on[d]   = 1;
        next_ready[d] = k + 1;
        held_data[d]  = '0;
        held_id[d]    = 1'b0;
      end
      return;
    end
    if (d == 0 && exp_q_a.size() > 0 && exp_q_a[0].due == 32'(k)) begin
      head = exp_q_a.pop_front(); due_now = 1;
    end
    if (d == 1 && exp_q_b.size() > 0 && exp_q_b[0].due == 32'(k)) begin
      head = exp_q_b.pop_front(); due_now = 1;
    end
    if (due_now) begin
      held_data[d] = head.data;
      held_id[d]   = head.id;
    end
    check($sformatf("dut%0d ready", d), LW'(ready), LW'(k >= next_ready[d]));
    check($sformatf("dut%0d rsp_valid", d), LW'(rv), LW'(due_now));
    check($sformatf("dut%0d rsp_data", d), rdat, held_data[d]);
    check($sformatf("dut%0d rsp_cache_id", d), LW'(rid), LW'(held_id[d]));
    if (rst) begin
      if (d == 0) exp_q_a.delete(); else exp_q_b.delete();
      next_ready[d] = k + 1;
      held_data[d]  = '0;
      held_id[d]    = 1'b0;
    end else begin
      if (due_now && head.wr) mstore[d][head.idx] = head.data;
      if (k >= next_ready[d] && v && (rd || wr)) begin
        idx      = addr[4 +: 12];
        ent.wr   = wr;
        ent.idx  = idx;
        ent.due  = 32'(k + lat);
        ent.id   = id;
        ent.data = wr ? wd : mstore[d][idx];
        if (d == 0) exp_q_a.push_back(ent); else exp_q_b.push_back(ent);
        next_ready[d] = k + lat + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, cyc, rst_a, valid_a, rd_a, wr_a, addr_a, wdata_a, id_a, ready_a, rvalid_a, rdata_a, rid_a);
    model_step(1, cyc, rst_b, valid_b, rd_b, wr_b, addr_b, wdata_b, id_b, ready_b, rvalid_b, rdata_b, rid_b);
  end

  // driver tasks
  task automatic issue_a(input logic rd, input logic wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] data, input logic id);
    int i;
    @(posedge clk); #1;
    valid_a = 1'b1; rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = data; id_a = id;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready_a) break;
    end
    if (i == 50) check("issue_a ready wait", '0, LW'(1));
    @(posedge clk); #1;
    valid_a = 1'b0; rd_a = 1'b0; wr_a = 1'b0;
  endtask

  task automatic wait_rsp_a(output logic [LW-1:0] d, output logic id, output int n);
    d = '0; id = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rvalid_a) begin
        n = i; d = rdata_a; id = rid_a;
        return;
      end
      check("ready low while busy", LW'(ready_a), '0);
    end
    n = -1;
  endtask

  task automatic final_report();
    if (!reported) begin
      reported = 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = $urandom;
    a[15:4] = 12'($urandom_range(0, 15));
    return a;
  endfunction

  // stimulus for the LATENCY=5 instance
  initial begin
    logic [LW-1:0] line10, a5s, old7, old1f, old21, d;
    logic          id;
    int            n;
    line10 = 128'h00112233445566778899AABBCCDDEEFF;
    a5s    = {16{8'hA5}};
    for (int i = 0; i < ML; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      dut_a.store[i] = d; mstore[0][i] = d;
      d = {$urandom, $urandom, $urandom, $urandom};
      dut_b.store[i] = d; mstore[1][i] = d;
    end
    dut_a.store['h10] = line10; mstore[0]['h10] = line10;
    old7 = mstore[0][7]; old1f = mstore[0]['h1F]; old21 = mstore[0]['h21];

    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    check("reset ready", LW'(ready_a), LW'(1));
    check("reset rsp_valid", LW'(rvalid_a), '0);
    check("reset rsp_data", rdata_a, '0);
    check("reset rsp_cache_id", LW'(rid_a), '0);
    repeat (20) begin
      @(negedge clk);
      check("idle rsp_valid", LW'(rvalid_a), '0);
    end

    issue_a(1'b1, 1'b0, 32'h100, '0, 1'b0);
    wait_rsp_a(d, id, n);
    check("read latency", LW'(n), LW'(LAT_A));
    check("read data", d, line10);
    check("read cache_id", LW'(id), '0);
    @(negedge clk);
    check("ready after rsp", LW'(ready_a), LW'(1));

    issue_a(1'b0, 1'b1, 32'h204, a5s, 1'b1);
    wait_rsp_a(d, id, n);
    check("write ack data", d, a5s);
    check("write ack cache_id", LW'(id), LW'(1));
    issue_a(1'b1, 1'b0, 32'h200, '0, 1'b0);
    wait_rsp_a(d, id, n);
    check("read after write", d, a5s);
    issue_a(1'b1, 1'b0, 32'h1F0, '0, 1'b0);
    wait_rsp_a(d, id, n);
    check("neighbour below", d, old1f);
    issue_a(1'b1, 1'b0, 32'h21C, '0, 1'b1);
    wait_rsp_a(d, id, n);
    check("neighbour above", d, old21);
    check("neighbour cache_id", LW'(id), LW'(1));

    issue_a(1'b1, 1'b0, 32'h100 + ML * 16, '0, 1'b0);
    wait_rsp_a(d, id, n);
    check("wrapped read", d, line10);

    @(posedge clk); #1;
    valid_a = 1'b1; rd_a = 1'b0; wr_a = 1'b0; addr_a = 32'h100;
    repeat (3) begin
      @(negedge clk);
      check("ignored req ready", LW'(ready_a), LW'(1));
      check("ignored req rsp", LW'(rvalid_a), '0);
    end
    @(posedge clk); #1 valid_a = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("no rsp after ignored", LW'(rvalid_a), '0);
    end

    issue_a(1'b0, 1'b1, 32'h70, ~old7, 1'b1);
    @(posedge clk); #1 rst_a = 1'b1;
    @(posedge clk); #1 rst_a = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("aborted write no rsp", LW'(rvalid_a), '0);
    end
    issue_a(1'b1, 1'b0, 32'h7C, '0, 1'b0);
    wait_rsp_a(d, id, n);
    check("aborted write store", d, old7);

    for (int t = 0; t < 60; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue_a(1'($urandom), 1'($urandom), rand_addr(), {$urandom, $urandom, $urandom, $urandom},
              1'($urandom));
    end
    repeat (LAT_A + 2) @(posedge clk);
    done_a = 1;
  end

  // stimulus for the LATENCY=1 instance
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n = 0;
    valid_b = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rd_b = 1'($urandom);
      wr_b = rd_b ? 1'($urandom) : 1'b1;
      addr_b = rand_addr(); wdata_b = {$urandom, $urandom, $urandom, $urandom}; id_b = 1'($urandom);
      @(negedge clk);
      if (rvalid_b) n++;
      @(posedge clk); #1;
    end
    valid_b = 1'b0;
    @(negedge clk);
    if (rvalid_b) n++;
    check("b2b response count", LW'(n), LW'(10));

    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      valid_b = ($urandom_range(0, 3) != 0);
      rd_b = 1'($urandom); wr_b = 1'($urandom);
      addr_b = rand_addr(); wdata_b = {$urandom, $urandom, $urandom, $urandom}; id_b = 1'($urandom);
    end
    @(posedge clk); #1 valid_b = 1'b0;
    repeat (4) @(posedge clk);
    done_b = 1;
  end

  initial begin
    wait (done_a && done_b);
    repeat (5) @(posedge clk);
    final_report();
    $finish;
  end

  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
    final_report();
    $finish;
  end

endmodule
